// File: rtl/inst_fetch_buf_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch buffer.
// The master side is fetch/decode; the slave side is the buffer itself.
interface inst_fetch_buf_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_i;
    logic [31:0]   inst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          flush_i;
    logic [31:0]   pc_o;
    logic [31:0]   inst_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] count_o;

    modport master (
        output pc_i, inst_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, pc_o, inst_o, out_valid_o, count_o
    );

    modport slave (
        input  pc_i, inst_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, pc_o, inst_o, out_valid_o, count_o
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// Small FIFO of (pc, instruction) pairs between fetch and decode with
// flush support; drives a canonical NOP at the head while empty.
module inst_fetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_fetch_buf_if.slave       bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          ready;
    logic          valid;

    // A full buffer refuses input even when decode pops in the same cycle.
    assign ready = (count != FULL);
    assign valid = (count != '0);
    assign push  = bus.in_valid_i & ready & ~bus.flush_i;
    assign pop   = valid & bus.out_ready_i & ~bus.flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents are don't-care until written, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.pc_i, bus.inst_i};
    end

    always_comb begin
        bus.in_ready_o  = ready;
        bus.out_valid_o = valid;
        bus.count_o     = count;
        bus.pc_o        = '0;
        bus.inst_o      = NOP_INST;
        if (valid) begin
            bus.pc_o   = mem[rd_ptr][63:32];
            bus.inst_o = mem[rd_ptr][31:0];
        end
    end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: reset, empty latency, fill/full,
// full-with-pop, flush, streaming across pointer wrap, and mid-run reset.
module tb_inst_fetch_buf;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inst_fetch_buf_if #(.DEPTH(DEPTH)) bus ();

    inst_fetch_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, 32'(bus.count_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready_o), 32'd1);
        check({tag, "_pc"}, bus.pc_o, 32'h0);
        check({tag, "_inst"}, bus.inst_o, NOP);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus.pc_i        = '0;
        bus.inst_i      = '0;
        bus.in_valid_i  = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        #2;
        check_empty("reset");
        tick();
        rst = 1'b1;

        // Empty: pushed pair is not visible in the push cycle.
        bus.in_valid_i = 1'b1;
        bus.pc_i       = 32'h20;
        bus.inst_i     = 32'h00500093;
        #1;
        check("empty_nobypass_valid", 32'(bus.out_valid_o), 32'd0);
        check("empty_nobypass_inst", bus.inst_o, NOP);
        tick();
        bus.in_valid_i = 1'b0;
        check("empty_latency_pc", bus.pc_o, 32'h20);
        check("empty_latency_inst", bus.inst_o, 32'h00500093);
        check("empty_latency_count", 32'(bus.count_o), 32'd1);
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        check("empty_drain_count", 32'(bus.count_o), 32'd0);

        // Fill four entries with decode stalled.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid_i = 1'b1;
            bus.pc_i       = 32'(i * 4);
            bus.inst_i     = 32'hA000_0000 | 32'(i * 4);
            tick();
        end
        check("fill_count", 32'(bus.count_o), 32'd4);
        check("fill_ready", 32'(bus.in_ready_o), 32'd0);
        check("fill_head_pc", bus.pc_o, 32'h0);
        bus.pc_i   = 32'h10;
        bus.inst_i = 32'hA000_0010;
        tick();
        check("full_ignore_count", 32'(bus.count_o), 32'd4);
        check("full_ignore_head", bus.pc_o, 32'h0);

        // Full with pop: pop accepted, simultaneous push refused.
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b0;
        check("fullpop_count", 32'(bus.count_o), 32'd3);
        check("fullpop_ready", 32'(bus.in_ready_o), 32'd1);
        check("fullpop_head_pc", bus.pc_o, 32'h4);
        check("fullpop_head_inst", bus.inst_o, 32'hA000_0004);

        // Flush with 3 entries held, push and pop both offered.
        bus.flush_i     = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.pc_i        = 32'h80;
        bus.inst_i      = 32'hA000_0080;
        bus.out_ready_i = 1'b1;
        tick();
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        check_empty("flush");
        bus.pc_i   = 32'h100;
        bus.inst_i = 32'hA000_0100;
        tick();
        bus.in_valid_i = 1'b0;
        check("postflush_head_pc", bus.pc_o, 32'h100);
        check("postflush_count", 32'(bus.count_o), 32'd1);
        bus.out_ready_i = 1'b1;
        tick();
        check("postflush_drain", 32'(bus.count_o), 32'd0);

        // Streaming across several pointer wraps.
        bus.in_valid_i  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.pc_i   = 32'(i * 4);
            bus.inst_i = ~(32'(i * 4));
            tick();
            check("stream_count", 32'(bus.count_o), 32'd1);
            check("stream_pc", bus.pc_o, 32'(i * 4));
            check("stream_inst", bus.inst_o, ~(32'(i * 4)));
        end
        bus.in_valid_i = 1'b0;
        tick();
        bus.out_ready_i = 1'b0;
        check("stream_drain", 32'(bus.count_o), 32'd0);

        // Asynchronous reset mid-cycle with 3 entries held.
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_i   = 32'h200 + 32'(i * 4);
            bus.inst_i = 32'hB000_0000 + 32'(i);
            tick();
        end
        bus.in_valid_i = 1'b0;
        check("prereset_count", 32'(bus.count_o), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_empty("midreset");
        tick();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch_buf.md
# inst_fetch_buf

Instruction fetch buffer between the program counter / instruction ROM pair and the decode stage. It captures each (pc, instruction) pair produced by fetch into a small FIFO, presents the oldest pair to decode with a valid/ready handshake, and back-pressures fetch when full. It discards all buffered instructions on a control-flow flush. Empty-buffer output is a canonical NOP, so decode never sees stale data.

## Interface
- DEPTH, 4: number of entries; power of two, 2..16
- NOP_INST, 32'h00000013: instruction driven on inst_o while empty (addi x0,x0,0)
- clk  in  1  clock, all state updated on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_i  in  32  address of the instruction being delivered by fetch
- inst_i  in  32  instruction word read from ROM at pc_i
- in_valid_i  in  1  fetch presents a valid pair this cycle
- in_ready_o  in→out  1  buffer accepts a pair this cycle; used as fetch stall (PC must hold when low)
- flush_i  in  1  synchronous flush (jump/branch taken); empties buffer
- pc_o  out  32  pc of head entry; 32'h0 while empty
- inst_o  out  32  instruction of head entry; NOP_INST while empty
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  decode consumes head this cycle
- count_o  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap), occupancy counter.
- push = in_valid_i & in_ready_o & ~flush_i; pop = out_valid_o & out_ready_i & ~flush_i.
- in_ready_o = (count_o != DEPTH). Decided: no pop-through when full; a full buffer refuses input even if decode pops the same cycle.
- out_valid_o = (count_o != 0). pc_o/inst_o driven combinationally from entry at read pointer when non-empty; 0/NOP_INST when empty.
- Push: write entry at wr_ptr, wr_ptr+1. Pop: rd_ptr+1. Count: +1 push only, -1 pop only, unchanged both or neither.
- Pointers wrap DEPTH-1 -> 0 without special handling.
- Flush: count, wr_ptr, rd_ptr -> 0 at next edge; input pair offered that cycle is dropped; pop that cycle does not occur (decode must also squash). Flush overrides push and pop.
- Empty: no bypass; an instruction pushed into an empty buffer is visible the cycle after.
- in_valid_i while in_ready_o low: pair ignored; fetch is responsible for holding it.
- Storage contents need no reset; only pointers/count are reset.

## Timing
- Reset (rst low, asynchronous): count_o=0, pointers=0, out_valid_o=0, in_ready_o=1, pc_o=0, inst_o=NOP_INST immediately, without waiting for clk.
- Reset asserted mid-operation: all buffered entries lost; same values as above.
- Push-to-output latency: 1 cycle (push at edge N, out_valid_o high after N).
- Pop-to-next-head: next entry visible immediately after the popping edge.
- Full -> ready: in_ready_o high the cycle after the first pop from a full buffer.
- Flush latency: outputs show empty state after the flush edge; in_ready_o high the same cycle.
- Sustained throughput: 1 pair/cycle when non-full and decode ready.

## Test plan
- Reset: drive rst low mid-cycle with 3 entries held -> count_o=0, out_valid_o=0, inst_o=32'h00000013, pc_o=0 before next clk edge.
- Fill: out_ready_i=0, push pc 0,4,8,C -> count_o=4, in_ready_o=0; push of pc 0x10 ignored; head pc_o=0.
- Full with pop: full buffer, out_ready_i=1, in_valid_i=1 pc 0x10 -> pop pc 0 accepted, 0x10 rejected, count_o=3, in_ready_o=1 next cycle.
- Streaming/wrap: in_valid_i and out_ready_i held high for 20 cycles pc 0..0x4C -> count_o stays 1 after first cycle, output pcs in order 0,4,...,0x48 across pointer wraps, no drops or duplicates.
- Flush: 3 entries, flush_i=1 with in_valid_i=1 pc 0x80 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, 0x80 absent; following push pc 0x100 appears as head.
- Empty: count_o=0, push pc 0x20 inst 0x00500093 -> pc_o/inst_o show it one cycle later, not in push cycle.
